// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
//   Shares the core's single memory / ring-network port between the
//   instruction-fetch side and the data side. One transaction is outstanding
//   at a time. Data requests win arbitration because they are older in the
//   pipeline. A streak counter forces an instruction grant after STARVE_LIMIT
//   consecutive data grants that were made while a fetch was waiting.
//
// Ports
//   clk, rst          clock, synchronous active-low reset
//   i_req/i_addr      fetch request, held until i_rvalid
//   i_rvalid/i_rdata  fetch completion pulse and fetched word
//   d_req/d_head/d_addr/d_wdata  data request, held until d_rvalid
//                     d_head: [3]=write [2]=read|write [1]=!ll [0]=!sc
//   d_rvalid/d_rdata  data completion pulse and load/sc result
//   m_req/m_head/m_addr/m_wdata  issued request, fields latched at grant
//   m_ready           port accepts when m_req && m_ready
//   m_rvalid/m_rdata  response from the port
//   bus_err           pulses with rvalid when a response timed out
//
// Every output is a register or a decode of the state/latch registers.
module core_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int RESP_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_head,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic [3:0]  m_head,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        bus_err
);

  localparam logic [3:0] LIMIT        = 4'(STARVE_LIMIT);
  localparam bit         TIMEOUT_EN   = (RESP_TIMEOUT != 0);
  localparam logic [7:0] TIMEOUT_LAST = 8'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RESP,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  streak, streak_nxt;
  logic [7:0]  timer, timer_nxt;
  logic        owner_d, owner_d_nxt;   // 1: data side owns the transaction
  logic [3:0]  head_q, head_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic [31:0] rdata_q, rdata_nxt;
  logic        err_q, err_nxt;
  logic        grant_d;
  logic        resp_expected;

  // Saturating streak increment; never counts past the starvation limit.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= LIMIT) ? LIMIT : v + 4'd1;
  endfunction

  // Data wins unless a fetch is waiting and the data streak is used up.
  assign grant_d       = d_req && !(i_req && (streak == LIMIT));
  // Reads and store-conditionals return a response; plain writes do not.
  assign resp_expected = !head_q[3] || !head_q[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      streak  <= '0;
      timer   <= '0;
      owner_d <= 1'b0;
      head_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      streak  <= streak_nxt;
      timer   <= timer_nxt;
      owner_d <= owner_d_nxt;
      head_q  <= head_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    streak_nxt  = streak;
    timer_nxt   = timer;
    owner_d_nxt = owner_d;
    head_nxt    = head_q;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    rdata_nxt   = rdata_q;
    err_nxt     = err_q;
    case (state)
      S_IDLE: begin
        err_nxt = 1'b0;
        if (grant_d) begin
          head_nxt    = d_head;
          addr_nxt    = d_addr;
          wdata_nxt   = d_wdata;
          owner_d_nxt = 1'b1;
          streak_nxt  = i_req ? sat_inc(streak) : 4'd0;
          state_nxt   = S_ISSUE;
        end else if (i_req) begin
          head_nxt    = 4'b0111;
          addr_nxt    = i_addr;
          wdata_nxt   = '0;
          owner_d_nxt = 1'b0;
          streak_nxt  = 4'd0;
          state_nxt   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (m_ready) begin
          if (resp_expected) begin
            timer_nxt = '0;
            state_nxt = S_WAIT_RESP;
          end else begin
            rdata_nxt = '0;
            state_nxt = S_DONE;
          end
        end
      end
      S_WAIT_RESP: begin
        timer_nxt = timer + 8'd1;
        if (m_rvalid) begin
          rdata_nxt = m_rdata;
          state_nxt = S_DONE;
        end else if (TIMEOUT_EN && (timer == TIMEOUT_LAST)) begin
          rdata_nxt = '0;
          err_nxt   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign m_req    = (state == S_ISSUE);
  assign m_head   = head_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign i_rvalid = (state == S_DONE) && !owner_d;
  assign d_rvalid = (state == S_DONE) && owner_d;
  assign i_rdata  = rdata_q;
  assign d_rdata  = rdata_q;
  assign bus_err  = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter (STARVE_LIMIT=4, RESP_TIMEOUT=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, so every check sees the registered state of the cycle just entered.
module tb_core_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_head;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req;
  logic [3:0]  m_head;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        bus_err;

  int checks = 0;
  int failures = 0;

  core_mem_arbiter #(.STARVE_LIMIT(4), .RESP_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_head(d_head), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_head(m_head), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_head = 0; d_addr = 0;
    d_wdata = 0; m_ready = 0; m_rvalid = 0; m_rdata = 0;
    #1;
    step(); step();
    // reset state
    check_val("rst_m_req", 32'(m_req), 0);
    check_val("rst_m_addr", m_addr, 0);
    check_val("rst_m_head", 32'(m_head), 0);
    check_val("rst_i_rvalid", 32'(i_rvalid), 0);
    check_val("rst_d_rvalid", 32'(d_rvalid), 0);
    check_val("rst_bus_err", 32'(bus_err), 0);
    rst = 1'b1;
    step();

    // single fetch
    i_req = 1; i_addr = 32'h100; m_ready = 1;
    step();                                   // cycle 1: ISSUE
    check_val("fetch_m_req", 32'(m_req), 1);
    check_val("fetch_m_addr", m_addr, 32'h100);
    check_val("fetch_m_head", 32'(m_head), 32'h7);
    check_val("fetch_m_wdata", m_wdata, 0);
    m_rvalid = 1; m_rdata = 32'h1234;
    step();                                   // cycle 2: WAIT_RESP
    check_val("fetch_wait_m_req", 32'(m_req), 0);
    check_val("fetch_wait_i_rvalid", 32'(i_rvalid), 0);
    step();                                   // cycle 3: DONE
    m_rvalid = 0; i_req = 0;
    check_val("fetch_i_rvalid", 32'(i_rvalid), 1);
    check_val("fetch_i_rdata", i_rdata, 32'h1234);
    check_val("fetch_d_rvalid", 32'(d_rvalid), 0);
    step();
    check_val("fetch_after_i_rvalid", 32'(i_rvalid), 0);

    // simultaneous request: data first, then instruction
    i_req = 1; i_addr = 32'h300; d_req = 1; d_addr = 32'h200; d_head = 4'b0111;
    step();
    check_val("simul_first_addr", m_addr, 32'h200);
    step();
    m_rvalid = 1; m_rdata = 32'hAAAA;
    step();
    m_rvalid = 0; d_req = 0;
    check_val("simul_d_rvalid", 32'(d_rvalid), 1);
    check_val("simul_d_rdata", d_rdata, 32'hAAAA);
    check_val("simul_i_rvalid0", 32'(i_rvalid), 0);
    step();                                   // IDLE
    step();                                   // ISSUE for fetch
    check_val("simul_second_addr", m_addr, 32'h300);
    check_val("simul_second_head", 32'(m_head), 32'h7);
    step();
    m_rvalid = 1; m_rdata = 32'h5555;
    step();
    m_rvalid = 0; i_req = 0;
    check_val("simul_i_rvalid", 32'(i_rvalid), 1);
    check_val("simul_i_rdata", i_rdata, 32'h5555);
    step();

    // starvation: grants D,D,D,D,I repeated
    i_req = 1; i_addr = 32'h500; d_req = 1; d_addr = 32'h400; d_head = 4'b0111;
    m_ready = 1; m_rvalid = 1; m_rdata = 32'h0;
    for (int k = 0; k < 10; k++) begin
      step();                                 // ISSUE
      check_val($sformatf("starve_grant%0d", k), m_addr,
                (k % 5 == 4) ? 32'h500 : 32'h400);
      step();                                 // WAIT_RESP
      step();                                 // DONE
      check_val($sformatf("starve_rv%0d", k), 32'({i_rvalid, d_rvalid}),
                (k % 5 == 4) ? 32'h2 : 32'h1);
      if (k == 9) begin
        i_req = 0; d_req = 0; m_rvalid = 0;
      end
      step();                                 // IDLE
    end

    // plain write with backpressure
    d_req = 1; d_head = 4'b1111; d_addr = 32'h600; d_wdata = 32'hDEAD;
    m_ready = 0;
    step();
    d_addr = 32'hBAD; d_wdata = 32'h0;        // latched fields must not follow
    m_rvalid = 1; m_rdata = 32'hFFFF;         // stray response
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("wr_m_req%0d", k), 32'(m_req), 1);
      check_val($sformatf("wr_addr%0d", k), m_addr, 32'h600);
      step();
    end
    check_val("wr_m_req3", 32'(m_req), 1);
    check_val("wr_wdata3", m_wdata, 32'hDEAD);
    check_val("wr_head3", 32'(m_head), 32'hF);
    m_ready = 1;
    step();                                   // DONE directly
    d_req = 0;
    check_val("wr_d_rvalid", 32'(d_rvalid), 1);
    check_val("wr_d_rdata", d_rdata, 0);
    check_val("wr_m_req_done", 32'(m_req), 0);
    check_val("wr_bus_err", 32'(bus_err), 0);
    step();                                   // IDLE, stray m_rvalid still high
    step();
    check_val("wr_stray_d_rvalid", 32'(d_rvalid), 0);
    check_val("wr_stray_m_req", 32'(m_req), 0);
    m_rvalid = 0;

    // store-conditional with response
    d_req = 1; d_head = 4'b1110; d_addr = 32'h700; d_wdata = 32'h42;
    step();                                   // ISSUE
    step();                                   // WAIT_RESP
    check_val("sc_wait_m_req", 32'(m_req), 0);
    step();
    check_val("sc_wait_d_rvalid", 32'(d_rvalid), 0);
    m_rvalid = 1; m_rdata = 32'h1;
    step();
    m_rvalid = 0; d_req = 0;
    check_val("sc_d_rvalid", 32'(d_rvalid), 1);
    check_val("sc_d_rdata", d_rdata, 32'h1);
    check_val("sc_bus_err", 32'(bus_err), 0);
    step();

    // store-conditional timeout
    d_req = 1; d_head = 4'b1110; d_addr = 32'h710;
    step();                                   // ISSUE
    step();                                   // WAIT_RESP entry
    for (int k = 1; k < 8; k++) begin
      step();
      check_val($sformatf("to_wait%0d", k), 32'({d_rvalid, bus_err}), 0);
    end
    step();                                   // 8 cycles after entry
    d_req = 0;
    check_val("to_d_rvalid", 32'(d_rvalid), 1);
    check_val("to_bus_err", 32'(bus_err), 1);
    check_val("to_d_rdata", d_rdata, 0);
    step();
    check_val("to_bus_err_clr", 32'(bus_err), 0);

    // reset mid-transaction
    i_req = 1; i_addr = 32'h800;
    step();                                   // ISSUE
    step();                                   // WAIT_RESP
    rst = 1'b0; i_req = 0;
    step();
    check_val("mid_rst_m_req", 32'(m_req), 0);
    check_val("mid_rst_m_addr", m_addr, 0);
    check_val("mid_rst_m_head", 32'(m_head), 0);
    check_val("mid_rst_rvalid", 32'({i_rvalid, d_rvalid, bus_err}), 0);
    check_val("mid_rst_i_rdata", i_rdata, 0);
    rst = 1'b1; m_rvalid = 1; m_rdata = 32'h99;
    step();
    step();
    check_val("late_rvalid", 32'({i_rvalid, d_rvalid}), 0);
    check_val("late_m_req", 32'(m_req), 0);
    m_rvalid = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares the core's single memory/ring-network port between the instruction-fetch side (pc/v_pc) and the data side (v_mem/mem_head/mem_addr/mem_data).
- Exactly one transaction is outstanding at a time. The block arbitrates, issues with a ready handshake, waits for the response if one is expected, and returns it to the owner.
- Data requests have priority because they are older in the pipeline. A streak counter bounds instruction-side starvation.
- Sits between core and the network interface.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while i_req is pending before instruction is forced. Legal range 1..15.
- RESP_TIMEOUT, 0: cycles to wait in WAIT_RESP before error completion. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is synchronous and active-low.
- i_req  in  1  instruction fetch request; held with i_addr until i_rvalid
- i_addr  in  32  fetch address
- i_rvalid  out  1  one-cycle completion pulse to fetch side
- i_rdata  out  32  fetched word, valid with i_rvalid
- d_req  in  1  data request; held with fields until d_rvalid
- d_head  in  4  [3]=write, [2]=read|write, [1]=!ll, [0]=!sc
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rvalid  out  1  one-cycle completion pulse to data side
- d_rdata  out  32  load/sc result, valid with d_rvalid
- m_req  out  1  request to memory port
- m_head  out  4  latched head
- m_addr  out  32  latched address
- m_wdata  out  32  latched write data
- m_ready  in  1  memory port accepts when m_req && m_ready
- m_rvalid  in  1  response valid
- m_rdata  in  32  response data
- bus_err  out  1  one-cycle pulse, coincident with rvalid, on timeout completion

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE, streak=0, timer=0.
  - All outputs 0 the following cycle.
  - Reset mid-transaction abandons the transaction with no rvalid. A late m_rvalid after reset is ignored.
- State IDLE:
  - If d_req && !(i_req && streak==STARVE_LIMIT): grant data. Latch d_head/d_addr/d_wdata, set owner=D.
  - Else if i_req: grant instruction. Latch head=4'b0111, addr=i_addr, wdata=0, set owner=I.
  - On any grant, go to ISSUE.
- Streak counter:
  - On a data grant with i_req high: streak+1, saturating at STARVE_LIMIT.
  - On a data grant with i_req low: streak=0.
  - On an instruction grant: streak=0.
- State ISSUE:
  - m_req=1 with the latched fields held stable.
  - On m_ready=1: go to WAIT_RESP if a response is expected, else DONE.
  - A response is expected iff head[3]==0 (read) or head[0]==0 (sc).
- State WAIT_RESP:
  - m_req=0; timer increments each cycle.
  - On m_rvalid: capture m_rdata, go to DONE.
  - Else if RESP_TIMEOUT!=0 && timer==RESP_TIMEOUT-1: capture 0, set err flag, go to DONE.
  - timer clears on entry.
- State DONE (exactly one cycle):
  - Owner's rvalid=1 with the captured data. Plain write completions carry rdata=0.
  - bus_err=err flag.
  - Go to IDLE.
- Requester rule: a requester sees rvalid at the end of DONE and must drop or replace req by the next cycle. Requests are sampled only in IDLE, so a completed request is never re-granted.
- m_rvalid and m_ready outside WAIT_RESP and ISSUE respectively are ignored.
- Read latency with m_ready=1 and a one-cycle memory:
  - req seen in IDLE at cycle 0.
  - m_req at cycle 1.
  - WAIT_RESP at cycle 2; m_rvalid at cycle 2.
  - rvalid at cycle 3.
  - Minimum 3 cycles from request to rvalid.
- Non-owner rvalid stays 0. rdata outputs hold their value outside DONE and are not meaningful then.
- All outputs are registered or derived only from the state/latch registers. There are no combinational paths from inputs to outputs.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, m_ready=1, m_rvalid with 0x1234 in the first WAIT_RESP cycle -> m_req high cycle 1 with m_addr=0x100, m_head=0111; i_rvalid=1, i_rdata=0x1234 at cycle 3; d_rvalid stays 0.
- Simultaneous request: i_req and d_req both high, d_addr=0x200 -> data issued first (m_addr=0x200); instruction issued in the next transaction after d_rvalid.
- Starvation, STARVE_LIMIT=4: d_req and i_req held high, data side re-requests after each completion -> grant order D,D,D,D,I,D…; streak returns to 0 after the I grant.
- Plain write, d_head=1111, m_ready low for 3 cycles then high -> m_req held 4 cycles with stable fields; DONE follows immediately; d_rvalid=1 with d_rdata=0; a stray m_rvalid is ignored.
- Store-conditional, d_head=1110 -> waits in WAIT_RESP; m_rvalid with 0x1 -> d_rdata=0x1. Timeout variant, RESP_TIMEOUT=8, no m_rvalid -> d_rvalid and bus_err pulse together 8 cycles after entering WAIT_RESP, with d_rdata=0.
- Reset mid-op: rst=0 during WAIT_RESP -> next cycle all outputs 0 and state IDLE; m_rvalid arriving afterwards produces no rvalid.
